// File: rtl/square_c.sv
// Sequential shift-add squarer: op_out = op_in^2 over a fixed 16-cycle CALC phase.
// Optional SQUARE_C_ADDEND_EN adds a 17-bit addend port, preloaded into the accumulator.
module square_c #(
   parameter int unsigned W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   op_in,
`ifdef SQUARE_C_ADDEND_EN
   input  logic [W:0]     addend_in,
`endif
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] op_out
);

   localparam int unsigned CW = $clog2(W) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state;
   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic [2*W-1:0] acc;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] preload;

`ifdef SQUARE_C_ADDEND_EN
   assign preload = {{(W-1){1'b0}}, addend_in};
`else
   assign preload = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= {{W{1'b0}}, op_in};
                  mplier <= op_in;
                  acc    <= preload;
                  cnt    <= '0;
                  state  <= CALC;
               end
            end
            CALC: begin
               // fixed latency: no early exit once the multiplier runs out of ones
               if (mplier[0])
                  acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(W - 1))
                  state <= DONE;
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign op_out    = acc;

endmodule
